// File: rtl/fractal_color_mapper.sv
// Iteration-count to 24-bit RGB colour stage: two-stage pipeline (index/mode, palette read/select)
// with valid/ready back-pressure, runtime-writable palette and per-frame palette rotation.
module fractal_color_mapper #(
    parameter int ITER_W = 8,
    parameter int PAL_AW = 8,
    parameter int RGB_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        cfg_mode,
    input  logic [ITER_W-1:0] cfg_max_iter,
    input  logic [RGB_W-1:0]  cfg_interior_rgb,
    input  logic              pal_we,
    input  logic [PAL_AW-1:0] pal_waddr,
    input  logic [RGB_W-1:0]  pal_wdata,
    input  logic [ITER_W-1:0] in_iter,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [RGB_W-1:0]  out_rgb,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PAL_AW-1:0] cycle_offset
);

    localparam int PAL_D = 2 ** PAL_AW;

    typedef enum logic [1:0] {
        SRC_FIXED = 2'd0,
        SRC_PAL   = 2'd1,
        SRC_INV   = 2'd2
    } src_t;

    function automatic logic [PAL_AW-1:0] pal_index(input logic [ITER_W-1:0] iter,
                                                    input logic [1:0] mode,
                                                    input logic [PAL_AW-1:0] offset);
        logic [PAL_AW-1:0] base;
        base = PAL_AW'(iter);
        pal_index = (mode == 2'd2) ? base + offset : base;
    endfunction

    function automatic src_t color_source(input logic interior, input logic [1:0] mode);
        if (interior || mode == 2'd1)
            color_source = SRC_FIXED;
        else if (mode == 2'd3)
            color_source = SRC_INV;
        else
            color_source = SRC_PAL;
    endfunction

    function automatic logic [RGB_W-1:0] color_select(input src_t src,
                                                      input logic [RGB_W-1:0] fixed,
                                                      input logic [RGB_W-1:0] pal_data);
        case (src)
            SRC_PAL: color_select = pal_data;
            SRC_INV: color_select = ~pal_data;
            default: color_select = fixed;
        endcase
    endfunction

    logic [RGB_W-1:0]  pal [PAL_D];

    logic              en;
    logic              interior;
    logic [7:0]        gray;

    logic              vld_p1;
    logic              last_p1;
    logic [PAL_AW-1:0] idx_p1;
    src_t              src_p1;
    logic [RGB_W-1:0]  fixed_p1;

    logic              vld_p2;
    logic              last_p2;
    src_t              src_p2;
    logic [RGB_W-1:0]  fixed_p2;
    logic [RGB_W-1:0]  pal_q_p2;

    assign en       = !vld_p2 || out_ready;
    assign in_ready = en;
    assign interior = (in_iter >= cfg_max_iter);
    assign gray     = in_iter[ITER_W-1 -: 8];

    // Palette writes are never stalled and continue through reset; contents are never cleared.
    always_ff @(posedge clk) begin
        if (pal_we)
            pal[pal_waddr] <= pal_wdata;
    end

    // Rotation steps once per accepted mode-2 frame end; that frame's pixels already used the old offset.
    always_ff @(posedge clk) begin
        if (!reset)
            cycle_offset <= '0;
        else if (in_valid && en && in_last && cfg_mode == 2'd2)
            cycle_offset <= cycle_offset + 1'b1;
    end

    // Stage 1: palette index, colour source and fixed colour, configuration sampled per pixel
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else if (en) begin
            vld_p1  <= in_valid;
            last_p1 <= in_valid && in_last;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            idx_p1   <= pal_index(in_iter, cfg_mode, cycle_offset);
            src_p1   <= color_source(interior, cfg_mode);
            fixed_p1 <= interior ? cfg_interior_rgb : {gray, gray, gray};
        end
    end

    // Stage 2: read-first palette read (write above lands in the same edge) and colour select
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p2  <= 1'b0;
            last_p2 <= 1'b0;
        end else if (en) begin
            vld_p2  <= vld_p1;
            last_p2 <= last_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            pal_q_p2 <= pal[idx_p1];
            src_p2   <= src_p1;
            fixed_p2 <= fixed_p1;
        end
    end

    assign out_valid = vld_p2;
    assign out_last  = last_p2;
    assign out_rgb   = vld_p2 ? color_select(src_p2, fixed_p2, pal_q_p2) : '0;

endmodule

// File: tb/tb_fractal_color_mapper.sv
// Directed, table-driven bench for fractal_color_mapper with hand-written back-pressure,
// palette write collision and reset-in-flight sequences.
module tb_fractal_color_mapper;

    logic        clk;
    logic        reset;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_max_iter;
    logic [23:0] cfg_interior_rgb;
    logic        pal_we;
    logic [7:0]  pal_waddr;
    logic [23:0] pal_wdata;
    logic [7:0]  in_iter;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] out_rgb;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  cycle_offset;

    fractal_color_mapper #(.ITER_W(8), .PAL_AW(8), .RGB_W(24)) dut (
        .clk(clk), .reset(reset),
        .cfg_mode(cfg_mode), .cfg_max_iter(cfg_max_iter), .cfg_interior_rgb(cfg_interior_rgb),
        .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
        .in_iter(in_iter), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .out_rgb(out_rgb), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .cycle_offset(cycle_offset)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  max_iter;
        logic [23:0] irgb;
        logic [7:0]  iter;
        logic        last;
        logic [23:0] exp_rgb;
    } vec_t;

    vec_t vt [32];
    int   total = 0;
    int   passed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    function automatic logic [23:0] pal_val(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, ~b, 8'h55};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic set_vec(input int i, input logic [1:0] mode, input logic [7:0] mx,
                           input logic [23:0] irgb, input logic [7:0] iter, input logic last,
                           input logic [23:0] exp_rgb);
        vt[i].mode = mode; vt[i].max_iter = mx; vt[i].irgb = irgb;
        vt[i].iter = iter; vt[i].last = last; vt[i].exp_rgb = exp_rgb;
    endtask

    task automatic drive_vec(input int i);
        cfg_mode = vt[i].mode; cfg_max_iter = vt[i].max_iter; cfg_interior_rgb = vt[i].irgb;
        in_iter = vt[i].iter; in_last = vt[i].last; in_valid = 1'b1;
    endtask

    // Back-to-back vectors; each result must appear exactly two cycles after its input.
    task automatic run_table(input int first, input int n);
        for (int k = 0; k < n + 2; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                check($sformatf("vec%0d_valid", first + k - 2), 32'(out_valid), 32'(1));
                check($sformatf("vec%0d_rgb", first + k - 2), 32'(out_rgb), 32'(vt[first + k - 2].exp_rgb));
                check($sformatf("vec%0d_last", first + k - 2), 32'(out_last), 32'(vt[first + k - 2].last));
            end
            if (k < n) drive_vec(first + k);
            else in_valid = 1'b0;
        end
    endtask

    initial begin
        logic [23:0] rx_rgb [$];
        logic        rx_last [$];
        logic [23:0] prev_rgb;
        logic        prev_last;
        bit          prev_stall;
        int          sent;
        int          got;

        reset = 1'b0; out_ready = 1'b1;
        cfg_mode = 2'd0; cfg_max_iter = 8'd255; cfg_interior_rgb = 24'h000000;
        pal_we = 1'b0; pal_waddr = 8'd0; pal_wdata = 24'd0;
        in_iter = 8'd1; in_last = 1'b1; in_valid = 1'b1;

        // Palette load while held in reset; the offered pixel must be ignored.
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            pal_we = 1'b1; pal_waddr = 8'(i); pal_wdata = pal_val(i);
        end
        @(negedge clk);
        pal_we = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_last", 32'(out_last), 32'(0));
        check("rst_out_rgb", 32'(out_rgb), 32'(0));
        check("rst_cycle_offset", 32'(cycle_offset), 32'(0));
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        check("post_rst_idle0", 32'(out_valid), 32'(0));
        @(negedge clk);
        check("post_rst_idle1", 32'(out_valid), 32'(0));

        // Basic modes, interior handling and per-pixel configuration sampling
        set_vec(0, 2'd0, 8'd255, 24'h000000, 8'd0,   1'b0, 24'h00FF55);
        set_vec(1, 2'd0, 8'd255, 24'h000000, 8'd1,   1'b0, 24'h01FE55);
        set_vec(2, 2'd0, 8'd255, 24'h000000, 8'd2,   1'b0, 24'h02FD55);
        set_vec(3, 2'd0, 8'd255, 24'h000000, 8'd254, 1'b0, 24'hFE0155);
        set_vec(4, 2'd0, 8'd255, 24'h000000, 8'd255, 1'b0, 24'h000000);
        set_vec(5, 2'd1, 8'd255, 24'h000000, 8'h80,  1'b0, 24'h808080);
        set_vec(6, 2'd3, 8'd255, 24'h000000, 8'd3,   1'b0, 24'hFC03AA);
        set_vec(7, 2'd1, 8'd255, 24'h123456, 8'hFF,  1'b0, 24'h123456);
        set_vec(8, 2'd3, 8'd100, 24'hABCDEF, 8'd200, 1'b0, 24'hABCDEF);
        set_vec(9, 2'd1, 8'd255, 24'h000000, 8'h3C,  1'b0, 24'h3C3C3C);
        set_vec(10, 2'd0, 8'd100, 24'h0F0F0F, 8'd100, 1'b0, 24'h0F0F0F);
        set_vec(11, 2'd3, 8'd255, 24'h000000, 8'd0,  1'b0, 24'hFF00AA);
        set_vec(12, 2'd2, 8'd255, 24'h000000, 8'd5,  1'b0, 24'h05FA55);
        set_vec(13, 2'd0, 8'd255, 24'h000000, 8'd9,  1'b1, 24'h09F655);
        run_table(0, 14);
        check("offset_after_basic", 32'(cycle_offset), 32'(0));

        // Three mode-2 frames of four pixels; each frame uses the offset before its last pixel
        for (int f = 0; f < 3; f++)
            for (int p = 0; p < 4; p++)
                set_vec(16 + f * 4 + p, 2'd2, 8'd255, 24'h000000, 8'd10, p == 3, pal_val(10 + f));
        run_table(16, 12);
        check("offset_after_3_frames", 32'(cycle_offset), 32'(3));

        // Advance the offset to 255 with single-pixel frames, then check the index wrap
        @(negedge clk);
        cfg_mode = 2'd2; cfg_max_iter = 8'd255; in_iter = 8'd40; in_last = 1'b1; in_valid = 1'b1;
        repeat (252) @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        repeat (3) @(negedge clk);
        check("offset_at_255", 32'(cycle_offset), 32'(255));
        set_vec(0, 2'd2, 8'd255, 24'h000000, 8'd1, 1'b0, 24'h00FF55);
        set_vec(1, 2'd2, 8'd255, 24'h000000, 8'd1, 1'b1, 24'h00FF55);
        set_vec(2, 2'd2, 8'd255, 24'h000000, 8'd1, 1'b0, 24'h01FE55);
        run_table(0, 3);
        check("offset_wrap_to_0", 32'(cycle_offset), 32'(0));

        // Back-pressure: out_ready low for five cycles in the middle of an eight-pixel burst
        cfg_mode = 2'd0; cfg_max_iter = 8'd255;
        sent = 0; got = 0; prev_stall = 0; prev_rgb = 24'd0; prev_last = 1'b0;
        for (int k = 0; k < 40 && got < 8; k++) begin
            @(negedge clk);
            out_ready = !(k >= 4 && k < 9);
            in_valid  = (sent < 8);
            in_iter   = 8'(20 + sent);
            in_last   = (sent == 7);
            #1;
            if (k == 4) begin
                check("bp_stall_out_valid", 32'(out_valid), 32'(1));
                check("bp_stall_in_ready", 32'(in_ready), 32'(0));
            end
            if (prev_stall) begin
                check("bp_hold_valid", 32'(out_valid), 32'(1));
                check("bp_hold_rgb", 32'(out_rgb), 32'(prev_rgb));
                check("bp_hold_last", 32'(out_last), 32'(prev_last));
            end
            prev_stall = out_valid && !out_ready;
            prev_rgb   = out_rgb;
            prev_last  = out_last;
            if (out_valid && out_ready) begin
                rx_rgb.push_back(out_rgb);
                rx_last.push_back(out_last);
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        check("bp_count", 32'(got), 32'(8));
        for (int i = 0; i < rx_rgb.size(); i++) begin
            check($sformatf("bp_rx%0d_rgb", i), 32'(rx_rgb[i]), 32'(pal_val(20 + i)));
            check($sformatf("bp_rx%0d_last", i), 32'(rx_last[i]), 32'(i == 7));
        end
        repeat (3) @(negedge clk);

        // Palette write landing on the same edge that reads address 7
        cfg_mode = 2'd0; cfg_max_iter = 8'd255;
        in_iter = 8'd7; in_last = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        pal_we = 1'b1; pal_waddr = 8'd7; pal_wdata = 24'hA1B2C3;
        @(negedge clk);
        pal_we = 1'b0; in_valid = 1'b0;
        check("raw_old_valid", 32'(out_valid), 32'(1));
        check("raw_old_rgb", 32'(out_rgb), 32'(24'h07F855));
        @(negedge clk);
        check("raw_new_valid", 32'(out_valid), 32'(1));
        check("raw_new_rgb", 32'(out_rgb), 32'(24'hA1B2C3));
        repeat (2) @(negedge clk);

        // Reset with two pixels in flight (second one also steps the offset)
        cfg_mode = 2'd0; in_iter = 8'd30; in_last = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        cfg_mode = 2'd2; in_iter = 8'd31; in_last = 1'b1;
        @(negedge clk);
        check("inflight_offset", 32'(cycle_offset), 32'(1));
        reset = 1'b0; cfg_mode = 2'd0; in_iter = 8'd50; in_last = 1'b0;
        @(negedge clk);
        check("rst2_out_valid", 32'(out_valid), 32'(0));
        check("rst2_out_rgb", 32'(out_rgb), 32'(0));
        check("rst2_out_last", 32'(out_last), 32'(0));
        check("rst2_offset", 32'(cycle_offset), 32'(0));
        reset = 1'b1; in_iter = 8'd7;
        @(negedge clk);
        in_valid = 1'b0;
        check("rst2_no_leftover", 32'(out_valid), 32'(0));
        @(negedge clk);
        check("rst2_first_valid", 32'(out_valid), 32'(1));
        check("rst2_first_rgb", 32'(out_rgb), 32'(24'hA1B2C3));
        @(negedge clk);
        check("rst2_drained", 32'(out_valid), 32'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fractal_color_mapper.md
Name: fractal_color_mapper

Overview:
- Parametrised, back-pressurable successor to the iteration-to-RGB colour stage of the fractal pipeline.
- Converts per-pixel escape-iteration counts into 24-bit RGB using one of four modes:
  - palette lookup from a runtime-writable palette RAM;
  - grayscale ramp;
  - palette with per-frame colour cycling;
  - inverted palette.
- Sits between the iteration engine and the frame-buffer/video writer.
- Passes a frame-end marker alongside each pixel.

Parameters:
- ITER_W, 8, iteration-count width; must be ≥ 8.
- PAL_AW, 8, palette address width; palette depth = 2^PAL_AW entries.
- RGB_W, 24, colour width; fixed 8:8:8, R in [23:16].

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- cfg_mode  in  2  0 palette, 1 grayscale, 2 palette+cycle, 3 inverted palette
- cfg_max_iter  in  ITER_W  iteration count treated as interior (did not escape)
- cfg_interior_rgb  in  RGB_W  colour emitted for interior pixels
- pal_we  in  1  palette write strobe
- pal_waddr  in  PAL_AW  palette write address
- pal_wdata  in  RGB_W  palette write data
- in_iter  in  ITER_W  pixel iteration count
- in_last  in  1  marks last pixel of a frame
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept a pixel this cycle
- out_rgb  out  RGB_W  mapped colour
- out_last  out  1  in_last delayed with its pixel
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts output
- cycle_offset  out  PAL_AW  current palette rotation offset, for debug

Behaviour:
- Handshakes:
  - Input transfer occurs on in_valid && in_ready.
  - Output transfer occurs on out_valid && out_ready.
  - out_valid/out_rgb/out_last must hold stable while out_valid && !out_ready.
- Pipeline:
  - 2 register stages: S1 (index/mode compute) and S2 (palette read, colour select).
  - Latency is exactly 2 cycles from input transfer to out_valid when unstalled.
  - Throughput is 1 pixel/clock.
- Stall:
  - Pipeline advance en = !out_valid || out_ready.
  - in_ready = en, combinational.
  - When en=0, both stages hold and bubbles are not compressed.
- Per-pixel sampling:
  - cfg_mode, cfg_max_iter and cfg_interior_rgb are sampled into S1 with each pixel.
  - Changing them mid-stream affects only later-accepted pixels.
- Interior: in_iter ≥ cfg_max_iter → out_rgb = cfg_interior_rgb in all modes.
- Mode 0: idx = in_iter[PAL_AW-1:0]; out_rgb = pal[idx].
- Mode 1: g = in_iter[ITER_W-1 -: 8]; out_rgb = {g,g,g}.
- Mode 2: idx = (in_iter + cycle_offset) mod 2^PAL_AW; out_rgb = pal[idx].
- Mode 3: out_rgb = ~pal[in_iter[PAL_AW-1:0]].
- Colour cycling:
  - cycle_offset increments by 1 on each input transfer with in_last=1 while cfg_mode=2.
  - It wraps from 2^PAL_AW-1 to 0.
  - Pixels of the accepting frame, including the last pixel, use the pre-increment offset.
- Palette RAM:
  - Single write port, synchronous read in S2.
  - The write is applied whenever pal_we=1, independent of stall.
  - Simultaneous write and read of the same address returns OLD data (read-first).
  - Contents are not cleared by reset.
- Reset (reset=0, checked on posedge):
  - out_valid=0, out_last=0, out_rgb=0, cycle_offset=0, all stage valids cleared.
  - Any in-flight pixels are discarded.
  - Input is ignored during reset.
  - Palette writes during reset are still performed.
- Width rules: the index addition truncates to PAL_AW bits; no saturation.

Test Plan:
1. Write pal[i]={i,~i,8'h55} for i=0..255, mode 0, cfg_max_iter=255, out_ready=1, feed iter 0,1,2,254,255 back-to-back → out_rgb 0x00FF55, 0x01FE55, 0x02FD55, 0xFE0155, then interior_rgb=0x000000, each exactly 2 cycles after its input.
2. Mode 1, iter=0x80 → 0x808080. Mode 3, iter=3 with pal[3]=0x03FC55 → 0xFC03AA.
3. Mode 2, send 4-pixel frame iter=10 with last on the 4th, repeated 3 frames:
   - out_rgb = pal[10], then pal[11], then pal[12] per frame;
   - cycle_offset = 3 after the third frame.
   - Separately, force offset 255, send iter=1 → pal[0].
4. Backpressure: stream 8 pixels, drive out_ready low for 5 cycles mid-stream:
   - in_ready drops in the same cycle;
   - out_rgb/out_last remain stable;
   - no pixel is lost or duplicated;
   - order is preserved.
5. pal_we to addr 7 in the same cycle S2 reads idx 7 → old value output; the next pixel with iter=7 sees the new value.
6. Assert reset with 2 pixels in flight:
   - next cycle out_valid=0 and cycle_offset=0;
   - after release, the first output corresponds to the first post-reset input;
   - palette contents are retained.
